ysyx_25020047_mem_arbiter: RTL and testbench
============================================

// Module: ysyx_25020047_mem_arbiter
// PURPOSE
//  Shares one single-port data memory between the IFU (read-only) and the LSU (read/write, byte mask).
//  Grants one requester at a time using 2-way round-robin, then runs a single outstanding
//  request/response transaction to memory. Returns the response to the owner and enforces a
//  response timeout. Sits between the IFU/LSU and the pmem/SRAM port in the multi-cycle NPC.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width; mask width = DATA_W/8
//  TIMEOUT  64  max cycles in WAIT before forced error response; 0 = no timeout
// PORTS
//  clk            in   1       single clock; all logic on posedge
//  rst            in   1       synchronous, active-high reset
//  ifu_req_valid  in   1       IFU fetch request
//  ifu_req_ready  out  1       IFU request accepted this cycle
//  ifu_addr       in   ADDR_W  fetch address
//  ifu_rsp_valid  out  1       one-cycle pulse, fetch data valid
//  ifu_rsp_data   out  DATA_W  fetched word
//  lsu_req_valid  in   1       LSU load/store request
//  lsu_req_ready  out  1       LSU request accepted this cycle
//  lsu_addr       in   ADDR_W  load/store address
//  lsu_wen        in   1       1 = store, 0 = load
//  lsu_wdata      in   DATA_W  store data, already lane-aligned
//  lsu_wmask      in   DATA_W/8  store byte-enable
//  lsu_rsp_valid  out  1       one-cycle pulse; load data valid or store done
//  lsu_rsp_data   out  DATA_W  raw loaded word (0 for stores)
//  mem_req_valid  out  1       request to memory
//  mem_req_ready  in   1       memory accepts request
//  mem_addr/mem_wen/mem_wdata/mem_wmask  out  -  registered copy of the granted request
//  mem_rsp_valid  in   1       memory response
//  mem_rsp_data   in   DATA_W  memory read data
//  err            out  1       one-cycle pulse on timeout
// BEHAVIOUR
//  - Reset: state=IDLE, last_grant=LSU (so IFU wins the first tie). All outputs 0. Request
//    registers cleared. Any in-flight transaction is abandoned with no response.
//  - FSM IDLE -> REQ -> WAIT -> IDLE.
//    IDLE: grant is combinational. Only one valid -> that one; both valid -> the one not in
//      last_grant. Exactly one *_req_ready=1 for the granted requester. On that cycle, latch
//      owner, addr, wen, wdata and wmask (IFU: wen=0, mask=0). Update last_grant. Go to REQ.
//      No valid -> stay. Both req_ready=0 in every state other than IDLE.
//    REQ: mem_req_valid=1 with fields held stable. On mem_req_ready=1 go to WAIT and clear
//      the timeout counter.
//    WAIT: mem_req_valid=0. On mem_rsp_valid=1, route a one-cycle pulse to the owner's
//      *_rsp_valid. Route mem_rsp_data to the owner's data output (LSU store: 0). Go to IDLE.
//      Otherwise the counter increments. When it reaches TIMEOUT (TIMEOUT!=0), pulse owner
//      rsp_valid with data 0, pulse err, and go to IDLE.
//  - Response pulses are registered: they appear the cycle after mem_rsp_valid. The data
//    output holds its last value until the next response.
//  - Minimum latency is 3 cycles from accept to rsp_valid with zero-wait memory; a new grant
//    is possible the cycle after the response.
//  - mem_rsp_valid in IDLE/REQ (stale or spurious) is ignored. No err pulse.
//  - Requesters must hold valid and fields until ready. The arbiter does not look at
//    unaligned addresses; the LSU has already aligned wdata/wmask.
//  - The counter is ceil(log2(TIMEOUT+1)) bits wide and saturates. It never wraps.
// STRUCTURE
//  - Package ysyx_25020047_mem_pkg: state enum {IDLE, REQ, WAIT}, owner encoding
//    (OWN_IFU=0, OWN_LSU=1), default ADDR_W/DATA_W.
//  - Sub-module ysyx_25020047_rr_arb2: 2-input round-robin picker (req[1:0], last -> gnt[1:0]),
//    purely combinational. Top-level holds FSM, request registers, timeout counter, response
//    routing.
// TESTING
//  1 IFU only, addr 0x8000_0000, mem ready+rsp immediate, data 0x0000_0413 -> ifu_rsp_valid
//    pulse 3 cycles after accept, data 0x0000_0413; lsu_rsp_valid stays 0.
//  2 IFU+LSU valid same cycle after reset -> IFU granted first, LSU next. Repeat with both
//    held -> strict alternation IFU,LSU,IFU,LSU.
//  3 LSU store addr 0x8000_0102, wdata 0x00AB_0000, wmask 0xC -> mem_wen=1, same
//    addr/wdata/wmask held through REQ with mem_req_ready low for 5 cycles; lsu_rsp_data=0.
//  4 TIMEOUT=8, memory never responds -> err and owner rsp_valid pulse exactly 8 cycles
//    after entering WAIT, data 0; a later mem_rsp_valid in IDLE is ignored.
//  5 rst asserted in WAIT -> next cycle IDLE, all outputs 0, no response pulse;
//    the next request gets IFU priority.

Source files
------------

// File: rtl/ysyx_25020047_mem_pkg.sv
// Shared types for the IFU/LSU data-memory arbiter: FSM states, owner encoding
// and default bus widths.
package ysyx_25020047_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Owner value doubles as the request/grant bit index in the picker.
    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

endpackage

// File: rtl/ysyx_25020047_rr_arb2.sv
// Two-input round-robin picker: a lone request wins outright, a tie goes to the
// requester that was not granted last time.
module ysyx_25020047_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        // NOTE: default assignment first so every path drives gnt; no latch is inferred.
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_25020047_mem_arbiter.sv
// Shares one single-port data memory between the IFU and LSU: round-robin grant,
// one outstanding request/response transaction, response routing and a wait timeout.
module ysyx_25020047_mem_arbiter
    import ysyx_25020047_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                err
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    state_t           state;
    owner_t           owner;
    owner_t           last_grant;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;
    logic [1:0]       gnt;

    ysyx_25020047_rr_arb2 u_rr_arb2 (
        .req  ({lsu_req_valid, ifu_req_valid}),
        .last (last_grant == OWN_LSU),
        .gnt  (gnt)
    );

    // Acceptance is combinational so a requester can hand off in the same cycle it asks.
    assign ifu_req_ready = (state == IDLE) && gnt[0];
    assign lsu_req_ready = (state == IDLE) && gnt[1];

    // Saturating increment; the count can never wrap back below the limit.
    assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every register, including the latched request fields, is reset so an
            // abandoned transaction leaves nothing visible on the outputs.
            state         <= IDLE;
            owner         <= OWN_IFU;
            last_grant    <= OWN_LSU;
            cnt           <= '0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            ifu_rsp_valid <= 1'b0;
            ifu_rsp_data  <= '0;
            lsu_rsp_valid <= 1'b0;
            lsu_rsp_data  <= '0;
            err           <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
            ifu_rsp_valid <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            err           <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt[0]) begin
                        owner         <= OWN_IFU;
                        last_grant    <= OWN_IFU;
                        mem_addr      <= ifu_addr;
                        mem_wen       <= 1'b0;
                        mem_wdata     <= '0;
                        mem_wmask     <= '0;
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
                    end else if (gnt[1]) begin
                        owner         <= OWN_LSU;
                        last_grant    <= OWN_LSU;
                        mem_addr      <= lsu_addr;
                        mem_wen       <= lsu_wen;
                        mem_wdata     <= lsu_wdata;
                        mem_wmask     <= lsu_wmask;
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        if (owner == OWN_IFU) begin
                            ifu_rsp_valid <= 1'b1;
                            ifu_rsp_data  <= mem_rsp_data;
                        end else begin
                            lsu_rsp_valid <= 1'b1;
                            lsu_rsp_data  <= mem_wen ? '0 : mem_rsp_data;
                        end
                        state <= IDLE;
                    end else if (timeout_hit) begin
                        if (owner == OWN_IFU) begin
                            ifu_rsp_valid <= 1'b1;
                            ifu_rsp_data  <= '0;
                        end else begin
                            lsu_rsp_valid <= 1'b1;
                            lsu_rsp_data  <= '0;
                        end
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25020047_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter; inputs change and outputs are
// sampled 1-2 time units after the rising edge.
module tb_ysyx_25020047_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                ifu_req_valid;
    logic                ifu_req_ready;
    logic [ADDR_W-1:0]   ifu_addr;
    logic                ifu_rsp_valid;
    logic [DATA_W-1:0]   ifu_rsp_data;
    logic                lsu_req_valid;
    logic                lsu_req_ready;
    logic [ADDR_W-1:0]   lsu_addr;
    logic                lsu_wen;
    logic [DATA_W-1:0]   lsu_wdata;
    logic [DATA_W/8-1:0] lsu_wmask;
    logic                lsu_rsp_valid;
    logic [DATA_W-1:0]   lsu_rsp_data;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_wen;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wmask;
    logic                mem_rsp_valid;
    logic [DATA_W-1:0]   mem_rsp_data;
    logic                err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ysyx_25020047_mem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ifu_req_valid(ifu_req_valid),
        .ifu_req_ready(ifu_req_ready),
        .ifu_addr     (ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_data (ifu_rsp_data),
        .lsu_req_valid(lsu_req_valid),
        .lsu_req_ready(lsu_req_ready),
        .lsu_addr     (lsu_addr),
        .lsu_wen      (lsu_wen),
        .lsu_wdata    (lsu_wdata),
        .lsu_wmask    (lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid),
        .lsu_rsp_data (lsu_rsp_data),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_addr     (mem_addr),
        .mem_wen      (mem_wen),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .err          (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        ifu_req_valid = 1'b0;
        ifu_addr      = '0;
        lsu_req_valid = 1'b0;
        lsu_addr      = '0;
        lsu_wen       = 1'b0;
        lsu_wdata     = '0;
        lsu_wmask     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        apply_reset();
        #1;
        flags = {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid,
                 mem_req_valid, mem_wen, err, 1'b0};
        tests_run++;
        if (flags !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 00000000", flags);
        end
        tests_run++;
        if ({mem_addr, mem_wdata, mem_wmask, ifu_rsp_data, lsu_rsp_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: addr %h wdata %h wmask %h ifu %h lsu %h expected all 0",
                     mem_addr, mem_wdata, mem_wmask, ifu_rsp_data, lsu_rsp_data);
        end
    endtask

    task automatic test_ifu_fetch();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        mem_req_ready = 1'b1;
        #1;
        tests_run++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL fetch_ready: got ifu/lsu %b%b expected 10", ifu_req_ready, lsu_req_ready);
        end
        step();                                   // REQ
        ifu_req_valid = 1'b0;
        tests_run++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_req: got valid %b addr %h wen %b expected 1 80000000 0",
                     mem_req_valid, mem_addr, mem_wen);
        end
        step();                                   // WAIT
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0413;
        tests_run++;
        if (mem_req_valid !== 1'b0 || ifu_rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_wait: got req_valid %b rsp_valid %b expected 0 0",
                     mem_req_valid, ifu_rsp_valid);
        end
        step();                                   // third cycle after accept
        mem_rsp_valid = 1'b0;
        tests_run++;
        if (ifu_rsp_valid !== 1'b1 || ifu_rsp_data !== 32'h0000_0413 || lsu_rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_rsp: got ifu %b data %h lsu %b expected 1 00000413 0",
                     ifu_rsp_valid, ifu_rsp_data, lsu_rsp_valid);
        end
        step();
        tests_run++;
        if (ifu_rsp_valid !== 1'b0 || ifu_rsp_data !== 32'h0000_0413) begin
            tests_failed++;
            $display("FAIL fetch_pulse: got valid %b data %h expected 0 00000413",
                     ifu_rsp_valid, ifu_rsp_data);
        end
    endtask

    task automatic test_alternation();
        logic        exp_ifu;
        logic [31:0] exp_addr;
        logic [31:0] rdata;
        apply_reset();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0010;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0200;
        lsu_wen       = 1'b0;
        mem_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_ifu  = (k % 2 == 0);
            exp_addr = exp_ifu ? 32'h8000_0010 : 32'h8000_0200;
            rdata    = 32'h0000_1000 + k;
            #1;
            tests_run++;
            if ({ifu_req_ready, lsu_req_ready} !== {exp_ifu, ~exp_ifu}) begin
                tests_failed++;
                $display("FAIL alt_grant[%0d]: got ifu/lsu %b%b expected %b%b",
                         k, ifu_req_ready, lsu_req_ready, exp_ifu, ~exp_ifu);
            end
            step();                               // REQ
            tests_run++;
            if (mem_addr !== exp_addr || {ifu_req_ready, lsu_req_ready} !== 2'b00) begin
                tests_failed++;
                $display("FAIL alt_req[%0d]: got addr %h ready %b%b expected %h 00",
                         k, mem_addr, ifu_req_ready, lsu_req_ready, exp_addr);
            end
            step();                               // WAIT
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = rdata;
            step();                               // back in IDLE with the response pulse
            mem_rsp_valid = 1'b0;
            tests_run++;
            if (exp_ifu ? (ifu_rsp_valid !== 1'b1 || lsu_rsp_valid !== 1'b0 || ifu_rsp_data !== rdata)
                        : (lsu_rsp_valid !== 1'b1 || ifu_rsp_valid !== 1'b0 || lsu_rsp_data !== rdata)) begin
                tests_failed++;
                $display("FAIL alt_rsp[%0d]: got ifu %b/%h lsu %b/%h expected owner ifu=%b data %h",
                         k, ifu_rsp_valid, ifu_rsp_data, lsu_rsp_valid, lsu_rsp_data, exp_ifu, rdata);
            end
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        step();
    endtask

    task automatic test_store_hold();
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0102;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'h00AB_0000;
        lsu_wmask     = 4'hC;
        mem_req_ready = 1'b0;
        #1;
        tests_run++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL store_ready: got ifu/lsu %b%b expected 01", ifu_req_ready, lsu_req_ready);
        end
        step();                                   // REQ
        lsu_req_valid = 1'b0;
        lsu_addr      = 32'hFFFF_FFFF;
        lsu_wdata     = 32'h1234_5678;
        lsu_wmask     = 4'h3;
        ifu_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (mem_req_valid !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== 32'h8000_0102 ||
                mem_wdata !== 32'h00AB_0000 || mem_wmask !== 4'hC || ifu_req_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL store_hold[%0d]: got v%b wen%b addr %h wdata %h mask %h ifu_rdy %b expected 1 1 80000102 00ab0000 c 0",
                         i, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, ifu_req_ready);
            end
            step();
        end
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();                                   // WAIT
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        step();
        mem_rsp_valid = 1'b0;
        tests_run++;
        if (lsu_rsp_valid !== 1'b1 || lsu_rsp_data !== 32'h0 || ifu_rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_rsp: got lsu %b data %h ifu %b expected 1 00000000 0",
                     lsu_rsp_valid, lsu_rsp_data, ifu_rsp_valid);
        end
        lsu_wen = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0040;
        step();                                   // REQ
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();                                   // entered WAIT
        mem_req_ready = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) begin
            step();
            tests_run++;
            if (err !== 1'b0 || ifu_rsp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL timeout_early[%0d]: got err %b rsp %b expected 0 0", i, err, ifu_rsp_valid);
            end
        end
        step();                                   // TIMEOUT cycles after entering WAIT
        tests_run++;
        if (err !== 1'b1 || ifu_rsp_valid !== 1'b1 || ifu_rsp_data !== 32'h0 || lsu_rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_fire: got err %b ifu %b data %h lsu %b expected 1 1 00000000 0",
                     err, ifu_rsp_valid, ifu_rsp_data, lsu_rsp_valid);
        end
        mem_rsp_valid = 1'b1;                     // stale response while IDLE
        mem_rsp_data  = 32'hCAFE_F00D;
        step();
        mem_rsp_valid = 1'b0;
        tests_run++;
        if (err !== 1'b0 || ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0 || ifu_rsp_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL stale_rsp: got err %b ifu %b lsu %b data %h expected 0 0 0 00000000",
                     err, ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_data);
        end
        step();
        tests_run++;
        if (ifu_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stale_idle: got rsp %b req_valid %b expected 0 0", ifu_rsp_valid, mem_req_valid);
        end
    endtask

    task automatic test_reset_in_wait();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0080;
        step();                                   // REQ
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();                                   // WAIT
        mem_req_ready = 1'b0;
        step();
        rst           = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h5555_AAAA;
        step();
        tests_run++;
        if ({mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, err, ifu_req_ready, lsu_req_ready} !== 6'b0 ||
            mem_addr !== 32'h0 || ifu_rsp_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL wait_reset: got req %b ifu %b lsu %b err %b rdy %b%b addr %h data %h expected all 0",
                     mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, err, ifu_req_ready, lsu_req_ready,
                     mem_addr, ifu_rsp_data);
        end
        rst           = 1'b0;
        mem_rsp_valid = 1'b0;
        step();
        tests_run++;
        if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_abandon: got ifu %b lsu %b err %b expected 0 0 0",
                     ifu_rsp_valid, lsu_rsp_valid, err);
        end
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_00C0;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0300;
        #1;
        tests_run++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL post_reset_prio: got ifu/lsu %b%b expected 10", ifu_req_ready, lsu_req_ready);
        end
        step();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        tests_run++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_00C0) begin
            tests_failed++;
            $display("FAIL post_reset_req: got valid %b addr %h expected 1 800000c0", mem_req_valid, mem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_ifu_fetch();
        test_alternation();
        test_store_hold();
        test_timeout();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
